// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command master's state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ahb_parity.sv
// Parity helper: par = ~^{data, sel}. Used both to generate the write
// parity bit and to flag a read parity mismatch (par=1 means mismatch).
module ahb_parity #(
  parameter int W = 16
) (
  input  logic [W-1:0] data,
  input  logic         sel,
  output logic         par
);

  // Inverted XOR reduction over the data word and the sense select.
  always_comb begin
    par = ~^{data, sel};
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite initiator: accepts one command, runs one
// NONSEQ word transfer (address phase, then data phase), and holds the
// response until taken. No pipelining of address phases.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int WAITCNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [15:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_parerr,
  output logic [WAITCNT_W-1:0] rsp_waits,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic                 PARITYSEL
);

  state_t               state_reg, state_next;
  logic                 accept;
  logic                 cmd_ready_reg;
  logic                 cmd_write_reg;
  logic [31:0]          cmd_addr_reg;
  logic [15:0]          cmd_wdata_reg;
  logic [WAITCNT_W-1:0] wait_cnt_reg;
  logic [16:0]          rsp_rdata_reg;
  logic                 rsp_err_reg;
  logic                 rsp_parerr_reg;
  logic [WAITCNT_W-1:0] rsp_waits_reg;
  logic                 wr_par;
  logic                 rd_par_bad;
  logic                 unused_hrdata;

  // Only the low 17 bits of read data (16 data + parity) are meaningful.
  assign unused_hrdata = ^HRDATA[31:17];

  ahb_parity #(.W(16)) u_wr_par (
    .data (cmd_wdata_reg),
    .sel  (PARITYSEL),
    .par  (wr_par)
  );

  ahb_parity #(.W(17)) u_rd_par (
    .data (HRDATA[16:0]),
    .sel  (PARITYSEL),
    .par  (rd_par_bad)
  );

  // Next-state decode and bus-phase outputs.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HWDATA     = 32'h0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          accept     = 1'b1;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        if (HREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (cmd_write_reg) HWDATA = {15'b0, wr_par, cmd_wdata_reg};
        if (HREADY) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; cmd_ready is registered so it stays low during reset
  // and rises on the first edge after release.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == ST_IDLE);
    end
  end

  // Command capture at acceptance only; drives the held address phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cmd_write_reg <= 1'b0;
      cmd_addr_reg  <= 32'h0;
      cmd_wdata_reg <= 16'h0;
    end else if (accept) begin
      cmd_write_reg <= cmd_write;
      cmd_addr_reg  <= cmd_addr;
      cmd_wdata_reg <= cmd_wdata;
    end
  end

  // Data-phase wait counter, saturating; HRESP during a wait is ignored.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt_reg <= '0;
    end else if (accept) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_DATA && !HREADY && wait_cnt_reg != '1) begin
      wait_cnt_reg <= wait_cnt_reg + WAITCNT_W'(1);
    end
  end

  // Response capture on the completing data-phase edge; held through RESP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_rdata_reg  <= 17'h0;
      rsp_err_reg    <= 1'b0;
      rsp_parerr_reg <= 1'b0;
      rsp_waits_reg  <= '0;
    end else if (state_reg == ST_DATA && HREADY) begin
      rsp_rdata_reg  <= cmd_write_reg ? 17'h0 : HRDATA[16:0];
      rsp_err_reg    <= HRESP;
      rsp_parerr_reg <= !cmd_write_reg && rd_par_bad;
      rsp_waits_reg  <= wait_cnt_reg;
    end
  end

  assign cmd_ready  = cmd_ready_reg;
  assign rsp_valid  = (state_reg == ST_RESP);
  assign rsp_rdata  = rsp_rdata_reg;
  assign rsp_err    = rsp_err_reg;
  assign rsp_parerr = rsp_parerr_reg;
  assign rsp_waits  = rsp_waits_reg;
  assign HADDR      = cmd_addr_reg;
  assign HWRITE     = cmd_write_reg;
  assign HSIZE      = HSIZE_WORD;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Self-checking bench for ahb_cmd_master: directed scenarios followed by
// randomized transfers checked against a behavioural response model.
module tb_ahb_cmd_master;

  localparam int WW = 8;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [31:0]   cmd_addr;
  logic [15:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [16:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_parerr;
  logic [WW-1:0] rsp_waits;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic          PARITYSEL;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int txn_cnt = 0;

  ahb_cmd_master #(.WAITCNT_W(WW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_parerr (rsp_parerr),
    .rsp_waits  (rsp_waits),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .PARITYSEL  (PARITYSEL)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer. Inputs change and outputs are sampled on negedges.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                        input logic psel, input int astall, input int dwaits,
                        input logic resp_in_wait, input logic resp_final,
                        input logic [31:0] rd, input int bp);
    logic [31:0] e_hwdata;
    logic [31:0] e_rdata;
    logic        e_wpar;
    logic        e_parerr;
    int          e_waits;

    // Behavioural expectations from the transfer description.
    e_wpar   = ($countones({wd, psel}) % 2) == 0;
    e_hwdata = wr ? {15'b0, e_wpar, wd} : 32'h0;
    e_rdata  = wr ? 32'h0 : {15'b0, rd[16:0]};
    e_parerr = !wr && (($countones({rd[16:0], psel}) % 2) == 0);
    e_waits  = (dwaits > (2**WW - 1)) ? (2**WW - 1) : dwaits;

    check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    PARITYSEL = psel;
    HREADY    = 1'($urandom_range(0, 1));
    HRESP     = 1'($urandom_range(0, 1));
    @(negedge HCLK);

    // Address phase; command inputs now carry junk that must be ignored.
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = 16'($urandom);
    check("addr_htrans", {30'b0, HTRANS}, 32'h2);
    check("addr_haddr", HADDR, addr);
    check("addr_hwrite", {31'b0, HWRITE}, {31'b0, wr});
    check("addr_hsize", {29'b0, HSIZE}, 32'h2);
    check("addr_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("addr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    for (int k = 0; k < astall; k++) begin
      HREADY = 1'b0;
      HRESP  = 1'($urandom_range(0, 1));
      @(negedge HCLK);
      check("astall_htrans", {30'b0, HTRANS}, 32'h2);
      check("astall_haddr", HADDR, addr);
      check("astall_hwrite", {31'b0, HWRITE}, {31'b0, wr});
    end
    HREADY = 1'b1;
    HRESP  = 1'($urandom_range(0, 1));
    @(negedge HCLK);

    // Data phase.
    check("data_htrans", {30'b0, HTRANS}, 32'h0);
    check("data_hwdata", HWDATA, e_hwdata);
    check("data_haddr_hold", HADDR, addr);
    check("data_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    for (int k = 0; k < dwaits; k++) begin
      HREADY = 1'b0;
      HRESP  = resp_in_wait;
      HRDATA = $urandom;
      @(negedge HCLK);
      check("dwait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("dwait_hwdata", HWDATA, e_hwdata);
      check("dwait_htrans", {30'b0, HTRANS}, 32'h0);
    end
    HREADY = 1'b1;
    HRESP  = resp_final;
    HRDATA = rd;
    @(negedge HCLK);

    // Response phase, held through any backpressure.
    HRESP  = 1'($urandom_range(0, 1));
    HREADY = 1'($urandom_range(0, 1));
    HRDATA = $urandom;
    for (int k = 0; k <= bp; k++) begin
      if (k > 0) begin
        rsp_ready = 1'b0;
        @(negedge HCLK);
      end
      check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("rsp_rdata", {15'b0, rsp_rdata}, e_rdata);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, resp_final});
      check("rsp_parerr", {31'b0, rsp_parerr}, {31'b0, e_parerr});
      check("rsp_waits", {24'b0, rsp_waits}, 32'(e_waits));
      check("rsp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rsp_htrans", {30'b0, HTRANS}, 32'h0);
    end
    $display("txn %0d: %s addr=%h wd=%h psel=%0d astall=%0d dwaits=%0d rdata=%h err=%0d parerr=%0d waits=%0d",
             txn_cnt, wr ? "WR" : "RD", addr, wd, psel, astall, dwaits,
             rsp_rdata, rsp_err, rsp_parerr, rsp_waits);
    txn_cnt++;
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 16'h0;
    rsp_ready = 1'b0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    PARITYSEL = 1'b0;
    repeat (3) @(negedge HCLK);

    // Reset state.
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_htrans", {30'b0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_rdata", {15'b0, rsp_rdata}, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_parerr", {31'b0, rsp_parerr}, 32'd0);
    check("rst_rsp_waits", {24'b0, rsp_waits}, 32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Directed scenarios.
    do_txn(1'b1, 32'h0000_0000, 16'h0001, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h0000_0004, 16'h0000, 1'b0, 0, 3, 1'b0, 1'b0, 32'h0001_A5A5, 0);
    do_txn(1'b0, 32'h0000_0004, 16'h0000, 1'b0, 0, 3, 1'b0, 1'b0, 32'h0000_A5A5, 0);
    do_txn(1'b1, 32'h0000_0008, 16'h0001, 1'b1, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h0000_0010, 16'h0000, 1'b0, 2, 1, 1'b1, 1'b1, 32'h0001_0000, 0);
    do_txn(1'b1, 32'h0000_0020, 16'hBEEF, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0, 5);

    // Reset while the data phase is stalled.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0100;
    cmd_wdata = 16'h1234;
    PARITYSEL = 1'b0;
    HREADY    = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("rd_addr_htrans", {30'b0, HTRANS}, 32'h2);
    @(negedge HCLK);
    check("rd_data_hwdata", HWDATA, 32'h0000_1234);
    HREADY = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("rd_rst_htrans", {30'b0, HTRANS}, 32'h0);
    check("rd_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rd_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rd_rst_hwdata", HWDATA, 32'h0);
    check("rd_rst_haddr", HADDR, 32'h0);
    check("rd_rst_waits", {24'b0, rsp_waits}, 32'd0);
    HRESET = 1'b0;
    HREADY = 1'b1;
    @(negedge HCLK);
    check("rd_rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rd_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    // Wait counter saturation.
    do_txn(1'b0, 32'h0000_0040, 16'h0000, 1'b1, 0, 300, 1'b0, 1'b0, 32'h0000_1111, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 The block SHALL have parameter WAITCNT_W, default 8, setting the width of the wait-state counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
REQ-003 The command and response ports SHALL be:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  response held until taken.
- rsp_ready  in  1  response taken when rsp_valid && rsp_ready.
- rsp_rdata  out  17  read data, bit 16 = received parity.
- rsp_err  out  1  slave returned HRESP=1.
- rsp_parerr  out  1  read parity mismatch.
- rsp_waits  out  WAITCNT_W  data-phase wait cycles.
REQ-004 The AHB-Lite initiator and parity ports SHALL be:
- HADDR  out  32  address.
- HTRANS  out  2  IDLE or NONSEQ only.
- HWRITE  out  1  direction.
- HSIZE  out  3  constant word size (3'b010).
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  error response.
- PARITYSEL  in  1  parity sense select.

Function
REQ-005 The block SHALL implement FSM states IDLE, ADDR, DATA and RESP.
REQ-006 cmd_ready SHALL be 1 only in IDLE.
REQ-007 On command acceptance, the block SHALL register the command and move to ADDR.
REQ-008 In ADDR, HTRANS SHALL be NONSEQ, and HADDR and HWRITE SHALL carry the registered command.
REQ-009 ADDR SHALL move to DATA at an edge where HREADY=1; otherwise it SHALL hold, with all address-phase outputs stable.
REQ-010 In all states other than ADDR, HTRANS SHALL be IDLE (2'b00), and HADDR and HWRITE SHALL hold their last values.
REQ-011 In DATA on a write, HWDATA SHALL be {15'b0, par, cmd_wdata}, where par = ~^{cmd_wdata, PARITYSEL} sampled in DATA.
REQ-012 In DATA on a read, HWDATA SHALL be 0.
REQ-013 In DATA, each edge with HREADY=0 SHALL increment the wait counter, saturating at all-ones.
REQ-014 In DATA, the edge with HREADY=1 SHALL capture the following and move to RESP:
- rsp_rdata <= HRDATA[16:0] (reads only; 0 for writes).
- rsp_err <= HRESP.
- rsp_parerr <= read && ~^{HRDATA[16:0], PARITYSEL}.
- rsp_waits <= wait counter.
REQ-015 rsp_valid SHALL be 1 only in RESP.
REQ-016 RESP SHALL move to IDLE on rsp_ready; all rsp_* values SHALL stay stable while rsp_valid && !rsp_ready.
REQ-017 The wait counter SHALL clear on command acceptance.
REQ-018 With HREADY=1 throughout, latency SHALL be accept edge -> ADDR 1 cycle -> DATA 1 cycle -> rsp_valid on the 3rd cycle after acceptance.
REQ-019 The minimum command-to-command period SHALL be 4 cycles; back-to-back overlap of address phases SHALL NOT be performed.
REQ-020 The block SHALL ignore HRESP outside DATA.
REQ-021 An HRESP=1 seen with HREADY=0 in DATA SHALL count as a wait cycle only.
REQ-022 The block SHALL ignore cmd_valid outside IDLE; command fields SHALL be registered only at acceptance.

Reset
REQ-023 While HRESET=1 at an edge, the block SHALL enter IDLE and set HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_parerr=0, rsp_waits=0 and wait counter=0.
REQ-024 cmd_ready SHALL rise on the first edge after HRESET deasserts.
REQ-025 A reset mid-transfer (ADDR, DATA or RESP) SHALL abandon the command with no response issued, and HTRANS SHALL be IDLE from the next cycle.

Structure
REQ-026 A shared package ahb_pkg SHALL hold:
- HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10).
- HSIZE_WORD=3'b010.
- the state enum type.
REQ-027 Parity generation and checking SHALL be one sub-module, ahb_parity, instantiated twice (write generation, read check).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Write: addr 0x0000_0000, wdata 0x0001, PARITYSEL=0, HREADY=1 -> NONSEQ for exactly 1 cycle, then HWDATA=0x0000_0001 (parity bit 0); rsp_valid 3 cycles after acceptance with err=0, waits=0.
- Read with waits: addr 0x04, slave holds HREADY=0 for 3 DATA cycles, then HRDATA=0x0001_A5A5, PARITYSEL=0 -> rsp_rdata=0x1A5A5, rsp_parerr=0, rsp_waits=3.
- Parity fault: same read, HRDATA=0x0000_A5A5 -> rsp_parerr=1; write with PARITYSEL=1, wdata 0x0001 -> HWDATA bit16=1.
- Address stall and error: HREADY=0 for 2 ADDR cycles -> HADDR/HTRANS stable; then HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> rsp_err=1, rsp_waits=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, HTRANS=IDLE; new command accepted 1 cycle after rsp_ready.
- Reset in DATA with HREADY=0 -> next cycle HTRANS=IDLE, rsp_valid=0; cmd_ready=1 on the first edge after release.
